// File: rtl/sva_mon_pkg.sv
// ============================================================================
// Module   : sva_mon_pkg
// Desc     : Shared types, widths and helpers for the implication monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sva_mon_pkg;

    localparam int CNT_W = 16;
    localparam int TS_W  = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FINAL = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sva_mon_tsfifo.sv
// ============================================================================
// Module   : sva_mon_tsfifo
// Desc     : Timestamp circular buffer with push, pop-head, flush and count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sva_mon_tsfifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [AW:0]   c_cnt_one = (AW + 1)'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic [AW-1:0] w_wr_idx;

    // A flush restarts the buffer at slot 0, so a same-cycle push lands there.
    assign w_wr_idx = i_flush ? '0 : r_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= i_push ? c_ptr_one : '0;
            r_cnt <= i_push ? c_cnt_one : '0;
        end else begin
            if (i_push) r_wr <= r_wr + c_ptr_one;
            if (i_pop)  r_rd <= r_rd + c_ptr_one;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[w_wr_idx] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/sva_impl_monitor.sv
// ============================================================================
// Module   : sva_impl_monitor
// Desc     : Bounded implication monitor a |-> ##[1:MAX_DELAY] b with verdict.
//            Optional SVA_MON_COVER_EN enables the antecedent hit counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sva_impl_monitor
    import sva_mon_pkg::*;
#(
    parameter int MAX_DELAY = 4,
    parameter int MAX_PEND  = 8,
    parameter int STRONG    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_i,
    input  logic                      b_i,
    input  logic                      end_i,
    output logic                      fail_o,
    output logic [CNT_W-1:0]          fail_cnt_o,
    output logic [CNT_W-1:0]          pass_cnt_o,
    output logic [$clog2(MAX_PEND):0] pending_o,
    output logic                      overflow_o,
    output logic                      done_o,
    output logic                      verdict_o,
    output logic [CNT_W-1:0]          cov_cnt_o
);

    localparam int PW = $clog2(MAX_PEND) + 1;
    localparam logic [TS_W-1:0]  c_max_dly  = TS_W'(MAX_DELAY);
    localparam logic [PW-1:0]    c_max_pend = PW'(MAX_PEND);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_run;
    logic             w_final;

    logic [TS_W-1:0]  r_cyc;
    logic [TS_W-1:0]  w_head;
    logic [TS_W-1:0]  w_age;
    logic [PW-1:0]    w_count;

    logic             w_pop;
    logic             w_flush;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic             w_final_fail;
    logic             w_done;

    logic             r_fail;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            RUN: begin
                w_run = 1'b1;
                if (end_i) w_state_nxt = FINAL;
            end
            FINAL: begin
                w_final     = 1'b1;
                w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_cyc <= '0;
        else       r_cyc <= r_cyc + TS_W'(1);
    end

    // Age wraps modulo 2^TS_W; live entries never exceed MAX_DELAY so this is unambiguous.
    assign w_age        = r_cyc - w_head;
    assign w_pop        = w_run & ~b_i & (w_count != '0) & (w_age == c_max_dly);
    assign w_flush      = (w_run & b_i) | w_final;
    assign w_push_req   = w_run & a_i;
    assign w_push       = w_push_req & ((w_count != c_max_pend) | w_pop | w_flush);
    assign w_drop       = w_push_req & ~w_push;
    assign w_final_fail = w_final & (STRONG != 0) & (w_count != '0);

    sva_mon_tsfifo #(
        .DEPTH (MAX_PEND),
        .W     (TS_W)
    ) u_tsfifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (r_cyc),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fail     <= 1'b0;
            r_fail_cnt <= '0;
            r_pass_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_fail <= w_pop | w_final_fail;
            if (w_pop)
                r_fail_cnt <= sat_add(r_fail_cnt, c_cnt_one);
            else if (w_final_fail)
                r_fail_cnt <= sat_add(r_fail_cnt, CNT_W'(w_count));
            if (w_run & b_i)
                r_pass_cnt <= sat_add(r_pass_cnt, CNT_W'(w_count));
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

`ifdef SVA_MON_COVER_EN
    logic [CNT_W-1:0] r_cov;

    always_ff @(posedge clk) begin
        if (reset)           r_cov <= '0;
        else if (w_push_req) r_cov <= sat_add(r_cov, c_cnt_one);
    end

    assign cov_cnt_o = r_cov;
`else
    assign cov_cnt_o = '0;
`endif

    assign w_done     = (r_state == DONE);
    assign fail_o     = r_fail;
    assign fail_cnt_o = r_fail_cnt;
    assign pass_cnt_o = r_pass_cnt;
    assign pending_o  = w_count;
    assign overflow_o = r_ovf;
    assign done_o     = w_done;
    assign verdict_o  = w_done & (r_fail_cnt == '0) & ~r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sva_impl_monitor.sv
// ============================================================================
// Module   : tb_sva_impl_monitor
// Desc     : Directed self-checking bench for sva_impl_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sva_impl_monitor;

    logic clk = 1'b0;
    logic reset, a_i, b_i, end_i;

    // u_dut: defaults; u_weak: STRONG=0; u_big: MAX_DELAY=16 so the buffer can fill
    logic        d_fail, d_ovf, d_done, d_verd;
    logic [15:0] d_fcnt, d_pcnt, d_cov;
    logic [3:0]  d_pend;
    logic        w_fail, w_ovf, w_done, w_verd;
    logic [15:0] w_fcnt, w_pcnt, w_cov;
    logic [3:0]  w_pend;
    logic        g_fail, g_ovf, g_done, g_verd;
    logic [15:0] g_fcnt, g_pcnt, g_cov;
    logic [3:0]  g_pend;

    int n_cmp = 0;
    int n_err = 0;
    int d_pulses, g_pulses;

    always #5 clk = ~clk;

    sva_impl_monitor #(.MAX_DELAY(4), .MAX_PEND(8), .STRONG(1)) u_dut (
        .clk(clk), .reset(reset), .a_i(a_i), .b_i(b_i), .end_i(end_i),
        .fail_o(d_fail), .fail_cnt_o(d_fcnt), .pass_cnt_o(d_pcnt), .pending_o(d_pend),
        .overflow_o(d_ovf), .done_o(d_done), .verdict_o(d_verd), .cov_cnt_o(d_cov));

    sva_impl_monitor #(.MAX_DELAY(4), .MAX_PEND(8), .STRONG(0)) u_weak (
        .clk(clk), .reset(reset), .a_i(a_i), .b_i(b_i), .end_i(end_i),
        .fail_o(w_fail), .fail_cnt_o(w_fcnt), .pass_cnt_o(w_pcnt), .pending_o(w_pend),
        .overflow_o(w_ovf), .done_o(w_done), .verdict_o(w_verd), .cov_cnt_o(w_cov));

    sva_impl_monitor #(.MAX_DELAY(16), .MAX_PEND(8), .STRONG(1)) u_big (
        .clk(clk), .reset(reset), .a_i(a_i), .b_i(b_i), .end_i(end_i),
        .fail_o(g_fail), .fail_cnt_o(g_fcnt), .pass_cnt_o(g_pcnt), .pending_o(g_pend),
        .overflow_o(g_ovf), .done_o(g_done), .verdict_o(g_verd), .cov_cnt_o(g_cov));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic a, input logic b, input logic e);
        a_i = a; b_i = b; end_i = e;
        @(posedge clk);
        #1;
        if (d_fail) d_pulses++;
        if (g_fail) g_pulses++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        reset = 1'b0;
        d_pulses = 0;
        g_pulses = 0;
    endtask

    initial begin
        reset = 1'b1; a_i = 1'b0; b_i = 1'b0; end_i = 1'b0;
        do_reset();
        check("rst_fail_o",   {31'd0, d_fail}, 0);
        check("rst_counts",   {d_fcnt, d_pcnt}, 0);
        check("rst_pending",  {28'd0, d_pend}, 0);
        check("rst_flags",    {29'd0, d_ovf, d_done, d_verd}, 0);
        check("rst_cov",      {16'd0, d_cov}, 0);

        // b at exactly age MAX_DELAY discharges
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        check("late_b_pass",  {16'd0, d_pcnt}, 1);
        check("late_b_fcnt",  {16'd0, d_fcnt}, 0);
        check("late_b_pulse", d_pulses, 0);
        check("late_b_pend",  {28'd0, d_pend}, 0);

        // no b: timeout pops at age 4, fail_o visible the following cycle
        do_reset();
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        check("to_before",    {15'd0, d_fcnt, d_fail}, 0);
        cyc(0, 0, 0);
        check("to_fail_o",    {31'd0, d_fail}, 1);
        check("to_fcnt",      {16'd0, d_fcnt}, 1);
        check("to_weak_fcnt", {16'd0, w_fcnt}, 1);
        check("to_big_pend",  {28'd0, g_pend}, 1);
        cyc(0, 0, 0);
        check("to_pulse_end", {31'd0, d_fail}, 0);
        check("to_pulses",    d_pulses, 1);

        // b in the antecedent cycle does not discharge the new obligation
        do_reset();
        cyc(1, 1, 0);
        check("same_cyc_pend", {28'd0, d_pend}, 1);
        check("same_cyc_pass", {16'd0, d_pcnt}, 0);

        // back-to-back a&b, trailing b, then end-of-test
        do_reset();
        repeat (6) cyc(1, 1, 0);
        cyc(0, 1, 0);
        check("ab_pass",      {16'd0, d_pcnt}, 6);
        check("ab_pend",      {28'd0, d_pend}, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 0, 1);
        check("ab_not_done",  {31'd0, d_done}, 0);
        cyc(0, 0, 0);
        check("ab_done",      {30'd0, d_done, d_verd}, 3);
        check("ab_fcnt",      {16'd0, d_fcnt}, 0);
        cyc(1, 1, 0);
        check("done_ignores", {12'd0, d_pend, d_pcnt}, {12'd0, 4'd0, 16'd6});

        // overflow: ninth antecedent dropped
        do_reset();
        repeat (8) cyc(1, 0, 0);
        check("ovf_pend8",    {28'd0, g_pend}, 8);
        check("ovf_not_yet",  {31'd0, g_ovf}, 0);
        cyc(1, 0, 0);
        check("ovf_set",      {31'd0, g_ovf}, 1);
        check("ovf_pend",     {28'd0, g_pend}, 8);
        check("ovf_no_fail",  {16'd0, g_fcnt}, 0);
`ifdef SVA_MON_COVER_EN
        check("ovf_cov",      {16'd0, g_cov}, 9);
`else
        check("ovf_cov",      {16'd0, g_cov}, 0);
`endif
        repeat (20) cyc(0, 0, 0);
        check("ovf_pulses",   g_pulses, 8);
        check("ovf_fcnt",     {16'd0, g_fcnt}, 8);
        check("ovf_drain",    {28'd0, g_pend}, 0);

        // push while full succeeds alongside a pop, and alongside a flush
        do_reset();
        repeat (8) cyc(1, 0, 0);
        repeat (8) cyc(0, 0, 0);
        cyc(1, 0, 0);
        check("full_pop_push", {27'd0, g_ovf, g_pend}, 8);
        check("full_pop_fcnt", {16'd0, g_fcnt}, 1);
        cyc(1, 1, 0);
        check("full_flush",    {11'd0, g_ovf, g_pend, g_pcnt}, {11'd0, 1'b0, 4'd1, 16'd8});

        // strong vs weak end-of-test with one open obligation
        do_reset();
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("strong_fail",  {15'd0, d_fail, d_fcnt}, {15'd0, 1'b1, 16'd1});
        check("strong_verd",  {28'd0, d_pend, d_done, d_verd}, {28'd0, 4'd0, 1'b1, 1'b0});
        check("weak_fail",    {15'd0, w_fail, w_fcnt}, 0);
        check("weak_verd",    {28'd0, w_pend, w_done, w_verd}, {28'd0, 4'd0, 1'b1, 1'b1});

        // reset while in FINAL
        do_reset();
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
        check("rst_final",    {13'd0, d_fail, d_fcnt, d_ovf, d_done}, 0);
        check("rst_final_pd", {28'd0, d_pend}, 0);
        cyc(1, 0, 0);
        check("rst_final_run", {28'd0, d_pend}, 1);
        cyc(0, 0, 0);
        check("rst_final_nop", d_pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
